// File: rtl/fetch_ctrl_pkg.sv
// Shared PC-source encodings, controller states and redirect priority helpers for the fetch stage.
// Pure declarations and functions; no latency or flow control of its own.
// Used by the redirect controller and its return-stack tracker.
package fetch_ctrl_pkg;

    localparam logic [2:0] PCSRC_SEQ     = 3'd0;
    localparam logic [2:0] PCSRC_JUMP    = 3'd1;
    localparam logic [2:0] PCSRC_BRANCH  = 3'd2;
    localparam logic [2:0] PCSRC_CALLRS1 = 3'd3;
    localparam logic [2:0] PCSRC_RET     = 3'd4;
    localparam logic [2:0] PCSRC_TRAP    = 3'd5;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic ret;
        logic call_rs1;
        logic call;
        logic jump;
        logic taken;
    } redir_t;

    // Highest-priority redirect wins; calls to an immediate share the jump mux leg.
    function automatic logic [2:0] redirect_select(input redir_t r);
        if (r.ret)      return PCSRC_RET;
        if (r.call_rs1) return PCSRC_CALLRS1;
        if (r.call)     return PCSRC_JUMP;
        if (r.jump)     return PCSRC_JUMP;
        if (r.taken)    return PCSRC_BRANCH;
        return PCSRC_SEQ;
    endfunction

    function automatic logic redirect_conflict(input redir_t r);
        return $countones(r) > 1;
    endfunction

endpackage

// File: rtl/ras_tracker.sv
// Return-address-stack occupancy tracker: gates push/pop strobes and records overflow/underflow.
// Strobes are combinational from requests; count and sticky flags update on the next clk edge.
// No backpressure: a push while full or pop while empty is dropped and flagged.
module ras_tracker
    import fetch_ctrl_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_req,
    input  logic          pop_req,
    output logic          ras_push,
    output logic          ras_pop,
    output logic          ras_empty,
    output logic [CW-1:0] ras_count,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    logic ras_full;

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign ras_push  = push_req & ~ras_full;
    assign ras_pop   = pop_req & ~ras_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (ras_push) begin
                ras_count <= ras_count + 1'b1;
            end else if (ras_pop) begin
                ras_count <= ras_count - 1'b1;
            end
            if (push_req & ras_full) begin
                ras_overflow <= 1'b1;
            end
            if (pop_req & ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_redirect_controller.sv
// Fetch-stage PC control: boot hold, redirect priority, multi-cycle kill flush and return-stack tracking.
// pc_source/pc_enable/kill/ras strobes are zero-latency; counters and sticky flags update next edge.
// stall freezes the PC and suppresses redirects; during FLUSH it also holds the flush counter.
module fetch_redirect_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int RAS_DEPTH   = 8,
    parameter int KILL_CYCLES = 1,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           sig_jump,
    input  logic                           sig_beq,
    input  logic                           sig_bne,
    input  logic                           sig_eq,
    input  logic                           sig_call,
    input  logic                           sig_call_rs1,
    input  logic                           sig_ret,
    output logic [2:0]                     pc_source,
    output logic                           pc_enable,
    output logic                           kill,
    output logic                           ras_push,
    output logic                           ras_pop,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           conflict,
    output logic [CNT_W-1:0]               redirect_count
);

    localparam int SEQ_MAX = (BOOT_CYCLES > KILL_CYCLES) ? BOOT_CYCLES : KILL_CYCLES;
    localparam int SW      = $clog2(SEQ_MAX + 1);

    state_t        state;
    logic [SW-1:0] seq_cnt;
    redir_t        req;
    logic [2:0]    winner;
    logic          accept;
    logic          any_redirect;
    logic          ras_empty;

    assign req = '{
        ret:      sig_ret,
        call_rs1: sig_call_rs1,
        call:     sig_call,
        jump:     sig_jump,
        taken:    (sig_beq & sig_eq) | (sig_bne & ~sig_eq)
    };

    assign accept       = (state == ST_RUN) & ~stall;
    assign winner       = redirect_select(req);
    assign any_redirect = accept & (winner != PCSRC_SEQ);

    // ret outranks both calls, so a push is only requested when no ret is present.
    ras_tracker #(
        .RAS_DEPTH (RAS_DEPTH),
        .CW        ($clog2(RAS_DEPTH + 1))
    ) u_ras (
        .clk           (clk),
        .reset         (reset),
        .push_req      (accept & (req.call | req.call_rs1) & ~req.ret),
        .pop_req       (accept & req.ret),
        .ras_push      (ras_push),
        .ras_pop       (ras_pop),
        .ras_empty     (ras_empty),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always_comb begin
        pc_source = PCSRC_SEQ;
        pc_enable = 1'b0;
        kill      = 1'b0;
        case (state)
            ST_BOOT: begin
                kill = 1'b1;
            end
            ST_RUN: begin
                pc_enable = ~stall;
                kill      = any_redirect;
                if (any_redirect) begin
                    // A return with nothing on the stack restarts at the trap vector.
                    pc_source = ((winner == PCSRC_RET) && ras_empty) ? PCSRC_TRAP : winner;
                end
            end
            ST_FLUSH: begin
                kill      = 1'b1;
                pc_enable = ~stall;
            end
            default: begin
                kill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_BOOT;
            seq_cnt        <= SW'(BOOT_CYCLES - 1);
            conflict       <= 1'b0;
            redirect_count <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if (seq_cnt == '0) state <= ST_RUN;
                    else               seq_cnt <= seq_cnt - 1'b1;
                end
                ST_RUN: begin
                    if (any_redirect && (KILL_CYCLES > 1)) begin
                        state   <= ST_FLUSH;
                        seq_cnt <= SW'(KILL_CYCLES - 2);
                    end
                end
                ST_FLUSH: begin
                    if (!stall) begin
                        if (seq_cnt == '0) state <= ST_RUN;
                        else               seq_cnt <= seq_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
            if (accept && redirect_conflict(req)) begin
                conflict <= 1'b1;
            end
            if (any_redirect && !(&redirect_count)) begin
                redirect_count <= redirect_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Bench for fetch_redirect_controller: a vector table plus hand sequences on KILL_CYCLES=1/3 instances,
// then random traffic checked against a cycle-level model of both instances.
module tb_fetch_redirect_controller;

    localparam int RAS_D = 8;
    localparam int MAXRC = 65535;

    typedef struct {
        bit rst, stall, jump, beq, bne, eq, call, crs1, ret;
    } in_t;

    typedef struct {
        int src;
        bit pe, kill, push, pop;
    } exp_t;

    typedef struct {
        int boot_left, flush_left, ras, rc;
        bit ovf, unf, conf;
    } mdl_t;

    typedef struct {
        in_t i;
        bit  chk;
        int  src;
        bit  pe, kill, push, pop;
        int  cnt;
        bit  ovf, unf, conf;
        int  rc;
    } vec_t;

    logic clk = 1'b0;
    logic reset, stall, sig_jump, sig_beq, sig_bne, sig_eq, sig_call, sig_call_rs1, sig_ret;

    logic [2:0]  a_src, b_src;
    logic        a_pe, a_kill, a_push, a_pop, a_ovf, a_unf, a_conf;
    logic        b_pe, b_kill, b_push, b_pop, b_ovf, b_unf, b_conf;
    logic [3:0]  a_cnt, b_cnt;
    logic [15:0] a_rc, b_rc;

    int checks = 0;
    int errors = 0;

    in_t  cur;
    mdl_t ma, mb;
    bit   mvalid = 1'b0;
    vec_t tab[$];

    always #5 clk = ~clk;

    fetch_redirect_controller #(.RAS_DEPTH(8), .KILL_CYCLES(1), .BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .sig_jump(sig_jump), .sig_beq(sig_beq),
        .sig_bne(sig_bne), .sig_eq(sig_eq), .sig_call(sig_call), .sig_call_rs1(sig_call_rs1),
        .sig_ret(sig_ret), .pc_source(a_src), .pc_enable(a_pe), .kill(a_kill), .ras_push(a_push),
        .ras_pop(a_pop), .ras_count(a_cnt), .ras_overflow(a_ovf), .ras_underflow(a_unf),
        .conflict(a_conf), .redirect_count(a_rc)
    );

    fetch_redirect_controller #(.RAS_DEPTH(8), .KILL_CYCLES(3), .BOOT_CYCLES(2), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .stall(stall), .sig_jump(sig_jump), .sig_beq(sig_beq),
        .sig_bne(sig_bne), .sig_eq(sig_eq), .sig_call(sig_call), .sig_call_rs1(sig_call_rs1),
        .sig_ret(sig_ret), .pc_source(b_src), .pc_enable(b_pe), .kill(b_kill), .ras_push(b_push),
        .ras_pop(b_pop), .ras_count(b_cnt), .ras_overflow(b_ovf), .ras_underflow(b_unf),
        .conflict(b_conf), .redirect_count(b_rc)
    );

    function automatic in_t mi(bit rst, bit st, bit jmp, bit beq, bit bne, bit eq, bit call, bit crs1, bit ret);
        in_t r;
        r.rst = rst; r.stall = st; r.jump = jmp; r.beq = beq; r.bne = bne;
        r.eq = eq; r.call = call; r.crs1 = crs1; r.ret = ret;
        return r;
    endfunction

    function automatic vec_t mkv(in_t i, bit chk, int src, bit pe, bit kill, bit push, bit pop,
                                 int cnt, bit ovf, bit unf, bit conf, int rc);
        vec_t v;
        v.i = i; v.chk = chk; v.src = src; v.pe = pe; v.kill = kill; v.push = push; v.pop = pop;
        v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.conf = conf; v.rc = rc;
        return v;
    endfunction

    function automatic mdl_t reset_model();
        mdl_t m;
        m.boot_left = 2; m.flush_left = 0; m.ras = 0; m.rc = 0;
        m.ovf = 1'b0; m.unf = 1'b0; m.conf = 1'b0;
        return m;
    endfunction

    // Reference: boot_left/flush_left count remaining held/killed slots; returns next model state.
    function automatic mdl_t model(input int kc, input in_t i, input mdl_t m, output exp_t e);
        mdl_t n;
        bit   tk;
        int   hits;
        n = m;
        e.src = 0; e.pe = 1'b0; e.kill = 1'b0; e.push = 1'b0; e.pop = 1'b0;
        tk = (i.beq && i.eq) || (i.bne && !i.eq);
        if (m.boot_left > 0) begin
            e.kill = 1'b1;
            n.boot_left = m.boot_left - 1;
        end else if (m.flush_left > 0) begin
            e.kill = 1'b1;
            e.pe   = !i.stall;
            if (!i.stall) n.flush_left = m.flush_left - 1;
        end else if (!i.stall) begin
            e.pe = 1'b1;
            hits = int'(i.ret) + int'(i.crs1) + int'(i.call) + int'(i.jump) + int'(tk);
            if (hits >= 2) n.conf = 1'b1;
            if (hits > 0) begin
                e.kill = 1'b1;
                if (m.rc < MAXRC) n.rc = m.rc + 1;
                n.flush_left = kc - 1;
                if (i.ret) begin
                    if (m.ras > 0) begin e.src = 4; e.pop = 1'b1; n.ras = m.ras - 1; end
                    else begin e.src = 5; n.unf = 1'b1; end
                end else if (i.crs1 || i.call) begin
                    e.src = i.crs1 ? 3 : 1;
                    if (m.ras < RAS_D) begin e.push = 1'b1; n.ras = m.ras + 1; end
                    else n.ovf = 1'b1;
                end else if (i.jump) begin
                    e.src = 1;
                end else begin
                    e.src = 2;
                end
            end
        end
        if (i.rst) n = reset_model();
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_inst(input string tag, input exp_t e, input mdl_t m,
                              input logic [2:0] src, input logic pe, input logic kill,
                              input logic push, input logic pop, input logic [3:0] cnt,
                              input logic ovf, input logic unf, input logic conf, input logic [15:0] rc);
        chk({tag, ".pc_source"}, 32'(src), 32'(e.src));
        chk({tag, ".pc_enable"}, 32'(pe), 32'(e.pe));
        chk({tag, ".kill"}, 32'(kill), 32'(e.kill));
        chk({tag, ".ras_push"}, 32'(push), 32'(e.push));
        chk({tag, ".ras_pop"}, 32'(pop), 32'(e.pop));
        chk({tag, ".ras_count"}, 32'(cnt), 32'(m.ras));
        chk({tag, ".ras_overflow"}, 32'(ovf), 32'(m.ovf));
        chk({tag, ".ras_underflow"}, 32'(unf), 32'(m.unf));
        chk({tag, ".conflict"}, 32'(conf), 32'(m.conf));
        chk({tag, ".redirect_count"}, 32'(rc), 32'(m.rc));
    endtask

    task automatic drive(input in_t i);
        cur = i;
        reset = i.rst; stall = i.stall; sig_jump = i.jump; sig_beq = i.beq; sig_bne = i.bne;
        sig_eq = i.eq; sig_call = i.call; sig_call_rs1 = i.crs1; sig_ret = i.ret;
        #2;
    endtask

    task automatic adv();
        exp_t ea, eb;
        mdl_t na, nb;
        na = model(1, cur, ma, ea);
        nb = model(3, cur, mb, eb);
        if (mvalid && !cur.rst) begin
            check_inst("k1", ea, ma, a_src, a_pe, a_kill, a_push, a_pop, a_cnt, a_ovf, a_unf, a_conf, a_rc);
            check_inst("k3", eb, mb, b_src, b_pe, b_kill, b_push, b_pop, b_cnt, b_ovf, b_unf, b_conf, b_rc);
        end
        ma = na;
        mb = nb;
        if (cur.rst) mvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t idle, rsti;
        idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rsti = mi(1, 0, 0, 0, 0, 0, 0, 0, 0);
        ma = reset_model();
        mb = reset_model();
        cur = idle;
        reset = 1'b1; stall = 1'b0; sig_jump = 1'b0; sig_beq = 1'b0; sig_bne = 1'b0;
        sig_eq = 1'b0; sig_call = 1'b0; sig_call_rs1 = 1'b0; sig_ret = 1'b0;
        @(posedge clk);
        #1;

        //            input                          chk src pe kl ps pp cnt ov un cf rc
        tab.push_back(mkv(rsti,                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mkv(idle,                         1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mkv(idle,                         1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mkv(idle,                         1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mkv(mi(0,0,0,1,0,1,0,0,0),        1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mkv(mi(0,0,0,1,0,0,0,0,0),        1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(mkv(mi(0,0,0,0,0,0,0,0,1),        1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(mkv(idle,                         1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2));
        tab.push_back(mkv(mi(0,0,0,0,0,0,1,0,0),        1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 2));
        tab.push_back(mkv(mi(0,0,0,0,0,0,0,0,1),        1, 4, 1, 1, 0, 1, 1, 0, 1, 0, 3));
        tab.push_back(mkv(idle,                         1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4));
        tab.push_back(mkv(mi(0,1,1,0,0,0,0,0,0),        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4));
        tab.push_back(mkv(mi(0,0,0,0,0,0,1,0,0),        1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 4));
        tab.push_back(mkv(mi(0,0,1,0,0,0,0,0,1),        1, 4, 1, 1, 0, 1, 1, 0, 1, 0, 5));
        tab.push_back(mkv(idle,                         1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 6));
        for (int k = 0; k < 9; k++)
            tab.push_back(mkv(mi(0,0,0,0,0,0,1,0,0), 1, 1, 1, 1, k < 8, 0, k, 0, 1, 1, 6 + k));
        tab.push_back(mkv(idle,                         1, 0, 1, 0, 0, 0, 8, 1, 1, 1, 15));
        tab.push_back(mkv(mi(0,0,0,0,0,0,0,1,0),        1, 3, 1, 1, 0, 0, 8, 1, 1, 1, 15));
        tab.push_back(mkv(mi(0,0,0,0,1,0,0,0,0),        1, 2, 1, 1, 0, 0, 8, 1, 1, 1, 16));
        tab.push_back(mkv(idle,                         1, 0, 1, 0, 0, 0, 8, 1, 1, 1, 17));

        for (int r = 0; r < tab.size(); r++) begin
            drive(tab[r].i);
            if (tab[r].chk) begin
                chk($sformatf("tab%0d.pc_source", r), 32'(a_src), 32'(tab[r].src));
                chk($sformatf("tab%0d.pc_enable", r), 32'(a_pe), 32'(tab[r].pe));
                chk($sformatf("tab%0d.kill", r), 32'(a_kill), 32'(tab[r].kill));
                chk($sformatf("tab%0d.ras_push", r), 32'(a_push), 32'(tab[r].push));
                chk($sformatf("tab%0d.ras_pop", r), 32'(a_pop), 32'(tab[r].pop));
                chk($sformatf("tab%0d.ras_count", r), 32'(a_cnt), 32'(tab[r].cnt));
                chk($sformatf("tab%0d.ras_overflow", r), 32'(a_ovf), 32'(tab[r].ovf));
                chk($sformatf("tab%0d.ras_underflow", r), 32'(a_unf), 32'(tab[r].unf));
                chk($sformatf("tab%0d.conflict", r), 32'(a_conf), 32'(tab[r].conf));
                chk($sformatf("tab%0d.redirect_count", r), 32'(a_rc), 32'(tab[r].rc));
            end
            adv();
        end

        // Three-slot flush with two stalls inside it, on the KILL_CYCLES=3 instance.
        drive(rsti); adv();
        drive(idle); adv();
        drive(idle); adv();
        drive(idle); adv();
        drive(mi(0,0,1,0,0,0,0,0,0));
        chk("flush.jump.kill", 32'(b_kill), 32'd1);
        chk("flush.jump.pc_enable", 32'(b_pe), 32'd1);
        chk("flush.jump.pc_source", 32'(b_src), 32'd1);
        adv();
        for (int s = 0; s < 2; s++) begin
            drive(mi(0,1,0,0,0,0,0,0,0));
            chk($sformatf("flush.stall%0d.kill", s), 32'(b_kill), 32'd1);
            chk($sformatf("flush.stall%0d.pc_enable", s), 32'(b_pe), 32'd0);
            adv();
        end
        drive(mi(0,0,1,0,0,0,0,0,0));
        chk("flush.ignjump.kill", 32'(b_kill), 32'd1);
        chk("flush.ignjump.pc_enable", 32'(b_pe), 32'd1);
        chk("flush.ignjump.pc_source", 32'(b_src), 32'd0);
        adv();
        drive(idle);
        chk("flush.last.kill", 32'(b_kill), 32'd1);
        chk("flush.last.pc_enable", 32'(b_pe), 32'd1);
        adv();
        drive(idle);
        chk("flush.done.kill", 32'(b_kill), 32'd0);
        chk("flush.done.pc_enable", 32'(b_pe), 32'd1);
        chk("flush.done.redirect_count", 32'(b_rc), 32'd1);
        adv();

        // Reset arriving in the middle of a flush.
        drive(mi(0,0,1,0,0,0,0,0,1)); adv();
        drive(rsti); adv();
        drive(idle);
        chk("midrst.kill", 32'(b_kill), 32'd1);
        chk("midrst.pc_enable", 32'(b_pe), 32'd0);
        chk("midrst.redirect_count", 32'(b_rc), 32'd0);
        chk("midrst.conflict", 32'(b_conf), 32'd0);
        chk("midrst.underflow", 32'(b_unf), 32'd0);
        adv();

        for (int n = 0; n < 600; n++) begin
            drive(mi($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0));
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
